// File: rtl/pkt_fifo_pkg.sv
// Shared types and constants for the single-clock show-ahead packet FIFO.
//   DATA_W        beat width in bits (SYMBOLS_PER_BEAT * BITS_PER_SYMBOL)
//   EMPTY_W       width of the empty-symbol count
//   CSR_ADDR_FILL CSR word address that returns the fill level
//   pkt_beat_t    one stored beat: data plus packet framing
package pkt_fifo_pkg;
  localparam int SYMBOLS_PER_BEAT = 64;
  localparam int BITS_PER_SYMBOL  = 8;
  localparam int DATA_W           = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int EMPTY_W          = 6;
  localparam int CSR_ADDR_W       = 3;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FILL = 3'd0;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } pkt_beat_t;
endpackage

// File: rtl/pkt_fifo_wrapper_infill_if.sv
// Bus bundle for pkt_fifo_wrapper_infill: CSR read port, Avalon-ST sink (in_*)
// and Avalon-ST source (out_*).
//   master : the environment around the FIFO (drives in_*, out_ready, csr_* strobes)
//   slave  : the FIFO itself (drives in_ready, out_*, csr_readdata)
interface pkt_fifo_wrapper_infill_if;
  import pkt_fifo_pkg::*;

  logic [CSR_ADDR_W-1:0] csr_address;
  logic                  csr_read;
  logic                  csr_write;
  logic [31:0]           csr_readdata;
  logic [31:0]           csr_writedata;

  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_startofpacket;
  logic                  in_endofpacket;
  logic [EMPTY_W-1:0]    in_empty;

  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_startofpacket;
  logic                  out_endofpacket;
  logic [EMPTY_W-1:0]    out_empty;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty,
    output out_ready,
    input  csr_readdata, in_ready,
    input  out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty,
    input  out_ready,
    output csr_readdata, in_ready,
    output out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );
endinterface

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port synchronous RAM holding pkt_beat_t entries.
//   clk      clock
//   wr_en    write strobe; wr_beat is stored at wr_addr
//   rd_en    read strobe; rd_beat takes mem[rd_addr] on the next edge and
//            holds it while rd_en is low
module pkt_fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pkt_beat_t         wr_beat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pkt_beat_t         rd_beat
);
  pkt_beat_t mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto block RAM; validity is tracked by the controller, not the data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_beat;
    if (rd_en) rd_beat <= mem[rd_addr];
  end
endmodule

// File: rtl/pkt_fifo_wrapper_infill.sv
// Single-clock show-ahead Avalon-ST packet FIFO with a fill-level CSR.
//   clk    sole clock
//   reset  asynchronous, active-high; discards all contents
//   bus    pkt_fifo_wrapper_infill_if.slave: CSR port, in_* sink, out_* source
// The head beat lives outside the RAM: it is either a bypass register loaded
// straight from the input (FIFO was otherwise empty) or the RAM read register.
// fill counts the head plus everything still in the RAM.
module pkt_fifo_wrapper_infill
  import pkt_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH  = 512,
  parameter bit USE_PACKETS = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  pkt_fifo_wrapper_infill_if.slave bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  logic [ADDR_W:0]   fill_q;
  logic [ADDR_W:0]   ram_count;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              out_valid_q;
  logic              head_sel_q;   // 1: head is the RAM read register
  logic [31:0]       csr_readdata_q;
  pkt_beat_t         in_beat;
  pkt_beat_t         byp_q;
  pkt_beat_t         ram_q;
  pkt_beat_t         head;
  logic              push;
  logic              pop;
  logic              head_free;
  logic              load_ram;
  logic              bypass;
  logic              ram_wr;

  // CSR writes have no effect on this block.
  logic unused_csr_write;
  assign unused_csr_write = ^{bus.csr_write, bus.csr_writedata};

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    in_beat       = '0;
    in_beat.data  = bus.in_data;
    if (USE_PACKETS) begin
      in_beat.sop   = bus.in_startofpacket;
      in_beat.eop   = bus.in_endofpacket;
      in_beat.empty = bus.in_empty;
    end
  end

  assign bus.in_ready = !reset && (fill_q < DEPTH_C);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = out_valid_q && bus.out_ready;

  // Entries sitting in the RAM behind the head.
  assign ram_count = fill_q - (ADDR_W+1)'(out_valid_q);
  assign head_free = !out_valid_q || pop;
  assign load_ram  = head_free && (ram_count != '0);
  // An empty RAM lets the incoming beat go straight to the head: one-cycle latency.
  assign bypass    = head_free && (ram_count == '0) && push;
  assign ram_wr    = push && !bypass;

  pkt_fifo_ram #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr_q),
    .wr_beat (in_beat),
    .rd_en   (load_ram),
    .rd_addr (rd_ptr_q),
    .rd_beat (ram_q)
  );

  always_ff @(posedge clk) begin
    if (bypass) byp_q <= in_beat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      head_sel_q     <= 1'b0;
      csr_readdata_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + (ADDR_W+1)'(1);
        2'b01:   fill_q <= fill_q - (ADDR_W+1)'(1);
        default: ;
      endcase

      if (ram_wr)   wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (load_ram) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);

      if (load_ram) begin
        out_valid_q <= 1'b1;
        head_sel_q  <= 1'b1;
      end else if (bypass) begin
        out_valid_q <= 1'b1;
        head_sel_q  <= 1'b0;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end

      if (bus.csr_read) begin
        csr_readdata_q <= (bus.csr_address == CSR_ADDR_FILL) ? 32'(fill_q) : 32'd0;
      end
    end
  end

  assign head                  = head_sel_q ? ram_q : byp_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = head.data;
  assign bus.out_startofpacket = head.sop;
  assign bus.out_endofpacket   = head.eop;
  assign bus.out_empty         = head.empty;
  assign bus.csr_readdata      = csr_readdata_q;
endmodule

// File: tb/tb_pkt_fifo_wrapper_infill.sv
// Directed bench for pkt_fifo_wrapper_infill. A reference queue and fill
// counter track what the FIFO must hold; outputs are sampled 1 time unit
// after each rising edge, inputs are changed at the same point.
module tb_pkt_fifo_wrapper_infill;
  import pkt_fifo_pkg::*;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic reset;

  pkt_fifo_wrapper_infill_if bus_if ();

  pkt_fifo_wrapper_infill #(.FIFO_DEPTH(DEPTH), .USE_PACKETS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          m_fill = 0;
  logic [31:0] m_csr  = '0;
  pkt_beat_t   m_q[$];
  pkt_beat_t   idle_beat = '0;

  function automatic pkt_beat_t mk_beat(input int idx, input logic sop, input logic eop,
                                        input logic [EMPTY_W-1:0] emp);
    pkt_beat_t r;
    r.data       = {SYMBOLS_PER_BEAT{8'(idx)}};
    r.data[31:0] = 32'(idx);
    r.sop        = sop;
    r.eop        = eop;
    r.empty      = emp;
    return r;
  endfunction

  function automatic pkt_beat_t head_beat();
    return {bus_if.out_data, bus_if.out_startofpacket, bus_if.out_endofpacket, bus_if.out_empty};
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic step(input logic iv, input pkt_beat_t b, input logic ordy, output logic pushed);
    logic push;
    logic pop;
    bus_if.in_valid         = iv;
    bus_if.in_data          = b.data;
    bus_if.in_startofpacket = b.sop;
    bus_if.in_endofpacket   = b.eop;
    bus_if.in_empty         = b.empty;
    bus_if.out_ready        = ordy;
    push = iv && (m_fill < DEPTH);
    pop  = ordy && (m_fill != 0);
    @(posedge clk);
    #1;
    if (bus_if.csr_read) m_csr = (bus_if.csr_address == CSR_ADDR_FILL) ? 32'(m_fill) : 32'd0;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(b);
    m_fill = m_fill + int'(push) - int'(pop);
    pushed = push;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset                = 1'b1;
    bus_if.in_valid      = 1'b0;
    bus_if.in_data       = '0;
    bus_if.in_startofpacket = 1'b0;
    bus_if.in_endofpacket   = 1'b0;
    bus_if.in_empty      = '0;
    bus_if.out_ready     = 1'b0;
    bus_if.csr_address   = CSR_ADDR_FILL;
    bus_if.csr_read      = 1'b1;
    bus_if.csr_write     = 1'b0;
    bus_if.csr_writedata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_held got %b exp 0", bus_if.in_ready);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_fill = 0; m_csr = '0; m_q.delete();
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", bus_if.in_ready);
    end
    checks++;
    if (bus_if.csr_readdata !== 32'd0) begin
      errors++; $display("FAIL reset_csr got %0d exp 0", bus_if.csr_readdata);
    end
  endtask

  task automatic test_single_beat();
    pkt_beat_t b;
    logic      p;
    b.data  = {SYMBOLS_PER_BEAT{8'hA5}};
    b.sop   = 1'b1;
    b.eop   = 1'b1;
    b.empty = 6'd5;
    step(1'b1, b, 1'b0, p);
    checks++;
    if (bus_if.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency out_valid got %b exp 1", bus_if.out_valid);
    end
    checks++;
    if (head_beat() !== b) begin
      errors++; $display("FAIL single_fields got %h exp %h", head_beat(), b);
    end
    checks++;
    if (bus_if.csr_readdata !== 32'd0) begin
      errors++; $display("FAIL single_csr_lag got %0d exp 0", bus_if.csr_readdata);
    end
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'd1) begin
      errors++; $display("FAIL single_csr got %0d exp 1", bus_if.csr_readdata);
    end
    checks++;
    if (head_beat() !== b) begin
      errors++; $display("FAIL single_hold got %h exp %h", head_beat(), b);
    end
    // Non-fill address reads 0; dropping csr_read holds the last value.
    bus_if.csr_address = 3'd1;
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'd0) begin
      errors++; $display("FAIL csr_other_addr got %0d exp 0", bus_if.csr_readdata);
    end
    bus_if.csr_address = CSR_ADDR_FILL;
    step(1'b0, idle_beat, 1'b0, p);
    bus_if.csr_read = 1'b0;
    step(1'b0, idle_beat, 1'b1, p);
    checks++;
    if (bus_if.csr_readdata !== 32'd1) begin
      errors++; $display("FAIL csr_hold got %0d exp 1", bus_if.csr_readdata);
    end
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop out_valid got %b exp 0", bus_if.out_valid);
    end
    bus_if.csr_read = 1'b1;
    step(1'b0, idle_beat, 1'b1, p);
    checks++;
    if (bus_if.csr_readdata !== m_csr) begin
      errors++; $display("FAIL single_empty_csr got %0d exp %0d", bus_if.csr_readdata, m_csr);
    end
  endtask

  task automatic test_fill_to_full();
    logic p;
    int   bad_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus_if.in_ready !== 1'b1) bad_ready++;
      step(1'b1, mk_beat(i, 1'b0, 1'b0, 6'(i)), 1'b0, p);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL fill_in_ready_drop got %0d low cycles exp 0", bad_ready);
    end
    checks++;
    if (bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_in_ready got %b exp 0", bus_if.in_ready);
    end
    step(1'b1, mk_beat(9999, 1'b1, 1'b1, 6'd1), 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'(DEPTH)) begin
      errors++; $display("FAIL full_fill got %0d exp %0d", bus_if.csr_readdata, DEPTH);
    end
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'(DEPTH)) begin
      errors++; $display("FAIL full_overflow got %0d exp %0d", bus_if.csr_readdata, DEPTH);
    end
    checks++;
    if (head_beat() !== m_q[0]) begin
      errors++; $display("FAIL full_head got %h exp %h", head_beat(), m_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    int   n = 0;
    for (int i = 0; i < 1000; i++) begin
      checks++;
      if (bus_if.in_ready !== (m_fill < DEPTH)) begin
        errors++; $display("FAIL stream_in_ready cyc %0d got %b exp %b", i, bus_if.in_ready, m_fill < DEPTH);
      end
      checks++;
      if (bus_if.out_valid !== 1'b1 || head_beat() !== m_q[0]) begin
        errors++; $display("FAIL stream_head cyc %0d got %h exp %h", i, head_beat(), m_q[0]);
      end
      step(1'b1, mk_beat(1000 + i, i[0], i[1], 6'(i)), 1'b1, p);
      checks++;
      if (bus_if.csr_readdata !== m_csr || bus_if.csr_readdata < 32'(DEPTH - 1)) begin
        errors++; $display("FAIL stream_fill cyc %0d got %0d exp %0d", i, bus_if.csr_readdata, m_csr);
      end
    end
    while (m_fill != 0 && n < 2 * DEPTH) begin
      checks++;
      if (bus_if.out_valid !== 1'b1 || head_beat() !== m_q[0]) begin
        errors++; $display("FAIL drain_head n %0d got %h exp %h", n, head_beat(), m_q[0]);
      end
      step(1'b0, idle_beat, 1'b1, p);
      n++;
    end
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty out_valid got %b exp 0", bus_if.out_valid);
    end
  endtask

  task automatic test_packets();
    pkt_beat_t stim[$];
    int        lens[3] = '{1, 4, 7};
    int        sent = 0;
    int        cyc  = 0;
    logic      p;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < lens[k]; i++)
        stim.push_back(mk_beat(16 * (k + 1) + i, i == 0, i == lens[k] - 1,
                               (i == lens[k] - 1) ? 6'(7 * k + 3) : 6'd0));
    while ((sent < stim.size() || m_fill != 0) && cyc < 2000) begin
      checks++;
      if (bus_if.out_valid !== (m_fill != 0)) begin
        errors++; $display("FAIL pkt_out_valid cyc %0d got %b exp %b", cyc, bus_if.out_valid, m_fill != 0);
      end
      if (m_fill != 0) begin
        checks++;
        if (head_beat() !== m_q[0]) begin
          errors++; $display("FAIL pkt_head cyc %0d got %h exp %h", cyc, head_beat(), m_q[0]);
        end
      end
      step((sent < stim.size()) ? 1'($urandom_range(0, 1)) : 1'b0,
           (sent < stim.size()) ? stim[sent] : idle_beat,
           1'($urandom_range(0, 1)), p);
      if (p) sent++;
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++; $display("FAIL pkt_timeout sent %0d fill %0d", sent, m_fill);
    end
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'd0 || bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL pkt_final fill got %0d valid %b exp 0 0", bus_if.csr_readdata, bus_if.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic p;
    for (int i = 0; i < 10; i++) step(1'b1, mk_beat(300 + i, 1'b0, 1'b0, 6'd0), 1'b0, p);
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.csr_readdata !== 32'd10) begin
      errors++; $display("FAIL mid_fill got %0d exp 10", bus_if.csr_readdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async valid %b ready %b exp 0 0", bus_if.out_valid, bus_if.in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fill = 0; m_csr = '0; m_q.delete();
    step(1'b0, idle_beat, 1'b0, p);
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.csr_readdata !== 32'd0) begin
      errors++; $display("FAIL mid_release ready %b fill %0d exp 1 0", bus_if.in_ready, bus_if.csr_readdata);
    end
    step(1'b1, mk_beat(77, 1'b1, 1'b0, 6'd0), 1'b0, p);
    checks++;
    if (bus_if.out_valid !== 1'b1 || head_beat() !== m_q[0]) begin
      errors++; $display("FAIL mid_after got %h exp %h", head_beat(), m_q[0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_fill_to_full();
    test_back_to_back();
    test_packets();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
